// File: rtl/aurora_hls_rx_fifo.sv
// aurora_hls_rx_fifo
//   Receive-side elastic buffer between an Aurora RX stream, which cannot be
//   stalled, and an AXI-Stream consumer. The output is first-word-fall-through.
//   When the buffer is full, incoming beats are dropped and counted. Two
//   registered watermarks drive the NFC XOFF/XON requests.
//
// Ports
//   clk, rst              single clock, asynchronous active-high reset
//   rx_t*                 Aurora RX beat (valid/data/keep/last), no backpressure
//   m_axis_t*             AXI-Stream master output, FWFT head of the buffer
//   fifo_rx_prog_full     occupancy >= PROG_FULL_THRESH (registered)
//   fifo_rx_prog_empty    occupancy <= PROG_EMPTY_THRESH (registered)
//   occupancy             stored beats, including the one on the output
//   overflow              sticky, set on the first dropped beat
//   drop_count            saturating dropped-beat counter

module aurora_hls_rx_fifo #(
    parameter int DATA_WIDTH        = 64,
    parameter int DEPTH             = 512,
    parameter int PROG_FULL_THRESH  = 384,
    parameter int PROG_EMPTY_THRESH = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx_tvalid,
    input  logic [DATA_WIDTH-1:0]       rx_tdata,
    input  logic [DATA_WIDTH/8-1:0]     rx_tkeep,
    input  logic                        rx_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic                        m_axis_tlast,
    output logic                        fifo_rx_prog_full,
    output logic                        fifo_rx_prog_empty,
    output logic [$clog2(DEPTH):0]      occupancy,
    output logic                        overflow,
    output logic [15:0]                 drop_count
);

    localparam int KW = DATA_WIDTH / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int EW = DATA_WIDTH + KW + 1;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] PF_C    = (AW+1)'(PROG_FULL_THRESH);
    localparam logic [AW:0] PE_C    = (AW+1)'(PROG_EMPTY_THRESH);

    generate
        if (PROG_EMPTY_THRESH >= PROG_FULL_THRESH || PROG_FULL_THRESH > DEPTH) begin : g_bad_thresh
            $error("aurora_hls_rx_fifo: illegal watermark thresholds");
        end
        if (DEPTH < 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("aurora_hls_rx_fifo: DEPTH must be a power of two >= 16");
        end
    endgenerate

    logic [EW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          armed_q, armed_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_count_q, drop_count_d;
    logic          prog_full_q, prog_full_d;
    logic          prog_empty_q, prog_empty_d;

    logic          not_empty;
    logic          full;
    logic          pop;
    logic          wr_en;
    logic          drop;

    always_comb begin
        not_empty = (count_q != '0);
        full      = (count_q == DEPTH_C);
        pop       = not_empty && m_axis_tready;
        // armed_q is low for the first cycle after reset release, so a beat
        // arriving in that cycle is neither stored nor counted as a drop.
        // When full, a same-cycle pop frees the head slot, which is exactly
        // the slot wr_ptr points at, so the beat is still accepted.
        wr_en     = armed_q && rx_tvalid && (!full || pop);
        drop      = armed_q && rx_tvalid && full && !pop;

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        armed_d      = 1'b1;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_en && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !wr_en) begin
            count_d = count_q - 1'b1;
        end

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end

        // Watermarks follow the current occupancy one cycle later.
        prog_full_d  = (count_q >= PF_C);
        prog_empty_d = (count_q <= PE_C);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            armed_q      <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
            prog_full_q  <= 1'b0;
            prog_empty_q <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            armed_q      <= armed_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            prog_full_q  <= prog_full_d;
            prog_empty_q <= prog_empty_d;
        end
    end

    // Storage has no reset; validity is carried entirely by count_q.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {rx_tdata, rx_tkeep, rx_tlast};
        end
    end

    always_comb begin
        m_axis_tvalid                              = not_empty;
        {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = mem[rd_ptr_q];
        fifo_rx_prog_full                          = prog_full_q;
        fifo_rx_prog_empty                         = prog_empty_q;
        occupancy                                  = count_q;
        overflow                                   = overflow_q;
        drop_count                                 = drop_count_q;
    end

endmodule

// File: tb/tb_aurora_hls_rx_fifo.sv
module tb_aurora_hls_rx_fifo;

    localparam int DW    = 64;
    localparam int KW    = DW / 8;
    localparam int DEPTH = 512;
    localparam int PF    = 384;
    localparam int PE    = 128;
    localparam int EW    = DW + KW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_tvalid = 1'b0;
    logic [DW-1:0] rx_tdata = '0;
    logic [KW-1:0] rx_tkeep = '0;
    logic          rx_tlast = 1'b0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          fifo_rx_prog_full;
    logic          fifo_rx_prog_empty;
    logic [9:0]    occupancy;
    logic          overflow;
    logic [15:0]   drop_count;

    int checks = 0;
    int errors = 0;

    aurora_hls_rx_fifo #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH),
        .PROG_FULL_THRESH(PF), .PROG_EMPTY_THRESH(PE)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_tvalid(rx_tvalid), .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep), .rx_tlast(rx_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .fifo_rx_prog_full(fifo_rx_prog_full), .fifo_rx_prog_empty(fifo_rx_prog_empty),
        .occupancy(occupancy), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored beats plus the bookkeeping flags.
    logic [EW-1:0] mq[$];
    bit            m_armed = 0;
    bit            m_ovf   = 0;
    int            m_drops = 0;
    bit            m_pf    = 0;
    bit            m_pe    = 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_armed = 0;
            m_ovf   = 0;
            m_drops = 0;
            m_pf    = 0;
            m_pe    = 1;
        end else begin
            int  occ;
            bit  pop;
            occ = mq.size();
            pop = (occ > 0) && m_axis_tready;
            m_pf = (occ >= PF);
            m_pe = (occ <= PE);
            if (m_armed && rx_tvalid) begin
                if (occ < DEPTH || pop) begin
                    if (pop) void'(mq.pop_front());
                    mq.push_back({rx_tdata, rx_tkeep, rx_tlast});
                    pop = 0;
                end else begin
                    m_ovf = 1;
                    if (m_drops < 65535) m_drops++;
                end
            end
            if (pop) void'(mq.pop_front());
            m_armed = 1;
        end
    end

    always @(negedge clk) begin
        check("tvalid", 128'(m_axis_tvalid), 128'(mq.size() > 0));
        check("occupancy", 128'(occupancy), 128'(mq.size()));
        check("prog_full", 128'(fifo_rx_prog_full), 128'(m_pf));
        check("prog_empty", 128'(fifo_rx_prog_empty), 128'(m_pe));
        check("overflow", 128'(overflow), 128'(m_ovf));
        check("drop_count", 128'(drop_count), 128'(m_drops));
        if (mq.size() > 0)
            check("head_beat", 128'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 128'(mq[0]));
    end

    task automatic step(input bit v, input bit r);
        @(posedge clk);
        #1;
        rx_tvalid     = v;
        m_axis_tready = r;
        rx_tdata      = {$urandom, $urandom};
        rx_tkeep      = 8'($urandom);
        rx_tlast      = 1'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0);
        @(negedge clk);
    endtask

    task automatic release_rst;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        rx_tvalid = 1'b1;   // must be ignored in the first cycle after release
        m_axis_tready = 1'b0;
    endtask

    initial begin
        // Reset held for two cycles.
        rst = 1'b1;
        idle(2);
        check("lit_rst_tvalid", 128'(m_axis_tvalid), 128'd0);
        check("lit_rst_occ", 128'(occupancy), 128'd0);
        check("lit_rst_pe", 128'(fifo_rx_prog_empty), 128'd1);
        check("lit_rst_pf", 128'(fifo_rx_prog_full), 128'd0);
        release_rst();
        idle(2);
        check("lit_first_cycle_ignored", 128'(occupancy), 128'd0);

        // Fill to the prog_full threshold.
        for (int i = 0; i < PF; i++) step(1, 0);
        idle(2);
        check("lit_fill_occ", 128'(occupancy), 128'd384);
        check("lit_fill_pf", 128'(fifo_rx_prog_full), 128'd1);
        check("lit_fill_pe", 128'(fifo_rx_prog_empty), 128'd0);

        // Drain completely.
        for (int i = 0; i < PF; i++) step(0, 1);
        idle(2);
        check("lit_drain_occ", 128'(occupancy), 128'd0);
        check("lit_drain_pf", 128'(fifo_rx_prog_full), 128'd0);
        check("lit_drain_pe", 128'(fifo_rx_prog_empty), 128'd1);

        // Overflow: 520 writes into 512 slots.
        for (int i = 0; i < 520; i++) step(1, 0);
        idle(2);
        check("lit_ovf_occ", 128'(occupancy), 128'd512);
        check("lit_ovf_flag", 128'(overflow), 128'd1);
        check("lit_ovf_drops", 128'(drop_count), 128'd8);

        // Full with simultaneous write and pop, then wrap over 3*DEPTH beats.
        for (int i = 0; i < 10; i++) step(1, 1);
        idle(2);
        check("lit_full_rw_occ", 128'(occupancy), 128'd512);
        check("lit_full_rw_drops", 128'(drop_count), 128'd8);
        for (int i = 0; i < 3 * DEPTH; i++) step(1, 1);
        idle(2);
        check("lit_wrap_occ", 128'(occupancy), 128'd512);
        check("lit_wrap_drops", 128'(drop_count), 128'd8);
        for (int i = 0; i < DEPTH; i++) step(0, 1);
        idle(2);
        check("lit_wrap_drain_occ", 128'(occupancy), 128'd0);

        // Mid-stream reset at occupancy 200.
        for (int i = 0; i < 200; i++) step(1, 0);
        idle(1);
        check("lit_pre_rst_occ", 128'(occupancy), 128'd200);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rx_tvalid = 1'b0;
        idle(2);
        check("lit_mid_rst_occ", 128'(occupancy), 128'd0);
        check("lit_mid_rst_ovf", 128'(overflow), 128'd0);
        check("lit_mid_rst_drops", 128'(drop_count), 128'd0);
        check("lit_mid_rst_pe", 128'(fifo_rx_prog_empty), 128'd1);
        release_rst();
        @(posedge clk);
        #1;
        rx_tvalid = 1'b1;
        rx_tdata  = 64'hDEAD_BEEF_0123_4567;
        rx_tkeep  = 8'hA5;
        rx_tlast  = 1'b1;
        idle(1);
        check("lit_post_rst_occ", 128'(occupancy), 128'd1);
        check("lit_post_rst_data", 128'(m_axis_tdata), 128'h0000_0000_0000_0000_DEAD_BEEF_0123_4567);
        check("lit_post_rst_keep", 128'(m_axis_tkeep), 128'hA5);

        // Randomized traffic with varying write/read intensity.
        for (int phase = 0; phase < 4; phase++) begin
            for (int i = 0; i < 1500; i++) begin
                bit v, r;
                case (phase)
                    0: begin v = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) == 0); end
                    1: begin v = ($urandom_range(0, 3) == 0); r = ($urandom_range(0, 3) != 0); end
                    2: begin v = 1'b1; r = 1'($urandom); end
                    default: begin v = 1'($urandom); r = 1'($urandom); end
                endcase
                step(v, r);
            end
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aurora_hls_rx_fifo.md
AURORA_HLS_RX_FIFO -- requirements
Module: aurora_hls_rx_fifo

Interface
REQ-001 SHALL have the following parameters, one per line (name, default, meaning):
- DATA_WIDTH, 64, RX beat width in bits.
- DEPTH, 512, number of stored beats; power of two, at least 16.
- PROG_FULL_THRESH, 384, occupancy at or above which fifo_rx_prog_full asserts.
- PROG_EMPTY_THRESH, 128, occupancy at or below which fifo_rx_prog_empty asserts.
REQ-002 SHALL have the following ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all logic is on its rising edge.
- rst, in, 1, asynchronous active-high reset.
- rx_tvalid, in, 1, Aurora RX beat valid; there is no ready signal and the source cannot be stalled.
- rx_tdata, in, DATA_WIDTH, RX beat data.
- rx_tkeep, in, DATA_WIDTH/8, RX byte enables.
- rx_tlast, in, 1, RX end of frame.
- m_axis_tvalid, out, 1, output beat valid.
- m_axis_tready, in, 1, consumer ready.
- m_axis_tdata, out, DATA_WIDTH, output data.
- m_axis_tkeep, out, DATA_WIDTH/8, output byte enables.
- m_axis_tlast, out, 1, output end of frame.
- fifo_rx_prog_full, out, 1, occupancy has reached PROG_FULL_THRESH; drives the NFC XOFF request.
- fifo_rx_prog_empty, out, 1, occupancy is at or below PROG_EMPTY_THRESH; drives the NFC XON request.
- occupancy, out, log2(DEPTH)+1, number of stored beats.
- overflow, out, 1, sticky flag set when a beat is dropped.
- drop_count, out, 16, saturating count of dropped beats.

REQ-003 SHALL treat clk as the only clock and rst as an asynchronous, active-high reset.

Function
REQ-004 SHALL store {tdata, tkeep, tlast} as one entry per write; a write occurs when rx_tvalid=1 and the FIFO is not full, or when the FIFO is full and a pop happens in the same cycle.
REQ-005 SHALL define a pop as m_axis_tvalid=1 and m_axis_tready=1 in the same cycle.
REQ-006 SHALL operate as first-word-fall-through: m_axis_tvalid rises exactly 1 cycle after a write into an empty FIFO, and the head entry is held stable while tvalid=1 and tready=0.
REQ-007 SHALL count occupancy as entries written and not yet popped, including the entry currently presented on the output, within the range 0..DEPTH.
REQ-008 SHALL update occupancy in the cycle after the event: +1 for a write only, -1 for a pop only, and no change for a simultaneous write and pop.
REQ-009 SHALL use read and write pointers of width log2(DEPTH) that wrap from DEPTH-1 to 0 with no gap or lost entry.
REQ-010 SHALL, on rx_tvalid=1 with occupancy=DEPTH and no pop:
- drop the beat;
- set overflow, which stays set until reset;
- increment drop_count, saturating at 0xFFFF;
- leave the stored contents and the pointers unchanged.
REQ-011 SHALL ignore a pop attempt while empty; m_axis_tvalid=0 then, and no state changes.
REQ-012 SHALL register fifo_rx_prog_full as (occupancy >= PROG_FULL_THRESH) and fifo_rx_prog_empty as (occupancy <= PROG_EMPTY_THRESH); each flag is valid 1 cycle after the occupancy change that causes it.
REQ-013 SHALL keep the two flags mutually exclusive; a parameter set with PROG_EMPTY_THRESH >= PROG_FULL_THRESH or PROG_FULL_THRESH > DEPTH is illegal and is flagged at elaboration.
REQ-014 SHALL drive rx_tlast and rx_tkeep through unaltered; no frame-level checking is performed.

Reset
REQ-015 SHALL, while rst=1, force:
- m_axis_tvalid=0, occupancy=0, both pointers 0;
- fifo_rx_prog_full=0, fifo_rx_prog_empty=1;
- overflow=0, drop_count=0.
REQ-016 SHALL discard all stored data when reset is asserted mid-operation; no beat presented before reset reappears after it.
REQ-017 SHALL ignore rx_tvalid during the first cycle after rst is released, and accept writes from the second cycle.

Verification
REQ-018 SHALL be covered by a directed bench with the following scenarios, using default parameters:
- Reset: hold rst=1 for 2 cycles, then release -> m_axis_tvalid=0, occupancy=0, prog_empty=1, prog_full=0.
- Fill: 384 consecutive writes with tready=0 -> prog_full rises 1 cycle after occupancy reaches 384; prog_empty falls 1 cycle after occupancy reaches 129.
- Drain: from 384, tready=1 with no writes -> prog_full falls at occupancy 383, prog_empty rises at occupancy 128, and the data arrives in write order.
- Overflow: 520 writes with tready=0 -> occupancy=512, overflow=1, drop_count=8, and the first 512 beats are read back intact.
- Full with simultaneous write and pop: at occupancy=512, rx_tvalid=1 and tready=1 for 10 cycles -> occupancy stays 512, drop_count unchanged, and the pointers wrap correctly over 3×DEPTH beats.
- Mid-stream reset: rst pulsed at occupancy=200 -> all outputs return to their reset values and the next written beat is the first beat read.
